dlx_fetch_unit: RTL and testbench
=================================

// Module: dlx_fetch_unit
// PURPOSE
//  Instruction-fetch initiator for the DLX instruction ROM. Owns the PC, drives the ROM word
//  address, captures the returned 32-bit instruction into the IF/ID register with its PC and
//  PC+1. Handles pipeline stall and taken-branch redirect from the decode/execute stages.
//  Sits between ROM_BLOCK (combinational responder) and the decode stage.
// PARAMETERS
//  ADDR_W     32  width of PC / ROM word address
//  DATA_W     32  instruction width
//  RESET_PC   0   PC value loaded at reset
//  ROM_DEPTH  64  number of valid ROM words (used only by bounds check)
// PORTS
//  clk_i            in   1       rising-edge clock
//  reset_i          in   1       asynchronous active-low reset
//  rom_addr_o       out  ADDR_W  word address to ROM (= PC register, no comb input path)
//  rom_data_i       in   DATA_W  instruction from ROM, valid same cycle as rom_addr_o
//  stall_i          in   1       hold PC and IF/ID register
//  branch_taken_i   in   1       redirect PC to branch_target_i
//  branch_target_i  in   ADDR_W  redirect word address
//  if_valid_o       out  1       IF/ID register holds a real instruction
//  if_instr_o       out  DATA_W  captured instruction
//  if_pc_o          out  ADDR_W  address of if_instr_o
//  if_npc_o         out  ADDR_W  if_pc_o + 1
//  fault_o          out  1       fetch out of bounds (0 unless macro defined)
// BEHAVIOUR
//  - Reset (reset_i=0, async, any time incl. mid-stall/redirect): pc=RESET_PC, state=BOOT,
//    if_valid_o=0, if_instr_o=0, if_pc_o=0, if_npc_o=0, fault_o=0.
//  - rom_addr_o always = pc register. Latency addr->if_instr_o: 1 clock.
//  - States: BOOT, RUN, HOLD (+FAULT with macro).
//  - BOOT: first edge after reset release -> RUN; no capture, if_valid_o stays 0 (1-cycle bubble).
//  - RUN/HOLD, per edge, priority high to low:
//    1. branch_taken_i=1 (wins over stall_i): pc<=branch_target_i, if_valid_o<=0,
//       if_instr_o<=0 (NOP), if_pc_o/if_npc_o hold; state->RUN.
//    2. stall_i=1: pc and all if_* outputs hold; state->HOLD.
//    3. else: if_instr_o<=rom_data_i, if_pc_o<=pc, if_npc_o<=pc+1, if_valid_o<=1,
//       pc<=pc+1; state->RUN.
//  - HOLD->RUN on first edge with stall_i=0 (capture occurs on that edge per rule 3).
//  - PC arithmetic modulo 2^ADDR_W: pc=all-ones increments to 0; if_npc_o wraps likewise.
//  - stall_i/branch_taken_i ignored in BOOT.
// CONFIGURATION
//  DLX_IF_BOUNDS_CHECK_EN defined: in RUN/HOLD, on an edge where rule 3 would fire and
//   pc>=ROM_DEPTH, enter FAULT instead: fault_o<=1, if_valid_o<=0, if_instr_o<=0, pc frozen.
//   FAULT exits only via reset; stall_i and branch_taken_i ignored. A branch to a target
//   >=ROM_DEPTH is accepted; fault raised on the following capture attempt.
//  Not defined: no FAULT state, fault_o tied 0, any pc value fetched without check.
// TESTING
//  1. Reset release, no stall: edge1 BOOT bubble; edge2 if_instr_o=0x40220000 pc=0 npc=1;
//     edge3 0x40230000 pc=1; edge6 0x6844000A pc=4, rom_addr_o=5.
//  2. stall_i=1 for 3 cycles at pc=5: rom_addr_o stays 5, if_* frozen, if_valid_o unchanged;
//     release -> next edge captures word 5 (0x40450001), pc=6.
//  3. branch_taken_i=1, target=0x0F, same cycle stall_i=1: next edge pc=0x0F, if_valid_o=0,
//     if_instr_o=0; following edge if_instr_o=0x40450001, if_pc_o=0x0F.
//  4. Force pc=0xFFFFFFFF via branch: capture gives if_pc_o=0xFFFFFFFF, if_npc_o=0, pc=0.
//  5. reset_i pulsed low mid-HOLD (between edges): outputs clear immediately, pc=0,
//     BOOT bubble repeats after release.
//  6. Macro defined: branch to 64 -> next capture edge fault_o=1, if_valid_o=0, pc=64 held
//     despite further branches; reset clears fault_o. Macro undefined: fault_o stays 0.

Source files
------------

// File: rtl/dlx_fetch_unit.sv
// -----------------------------------------------------------------------------
// dlx_fetch_unit
//
// Instruction-fetch initiator for the DLX instruction ROM. Owns the PC, presents
// it as the ROM word address, and captures the returned instruction into the
// IF/ID register together with its PC and PC+1. Handles decode-stage stall and
// execute-stage taken-branch redirect. The ROM is a combinational responder:
// rom_data_i reflects rom_addr_o within the same cycle.
//
// Optional feature: define DLX_IF_BOUNDS_CHECK_EN to add a sticky FAULT state
// entered when a capture is attempted at pc >= ROM_DEPTH. Without the macro
// fault_o is tied to 0 and any PC value is fetched unchecked.
//
// Ports
//   clk_i            in   1       rising-edge clock
//   reset_i          in   1       asynchronous active-low reset
//   rom_addr_o       out  ADDR_W  ROM word address (the PC register itself)
//   rom_data_i       in   DATA_W  instruction returned by the ROM
//   stall_i          in   1       hold PC and IF/ID register
//   branch_taken_i   in   1       redirect PC to branch_target_i (beats stall)
//   branch_target_i  in   ADDR_W  redirect word address
//   if_valid_o       out  1       IF/ID register holds a real instruction
//   if_instr_o       out  DATA_W  captured instruction (0 = NOP bubble)
//   if_pc_o          out  ADDR_W  address of if_instr_o
//   if_npc_o         out  ADDR_W  if_pc_o + 1 (modulo 2^ADDR_W)
//   fault_o          out  1       fetch out of bounds (bounds-check build only)
// -----------------------------------------------------------------------------
module dlx_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 ROM_DEPTH = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [ADDR_W-1:0] if_npc_o,
  output logic              fault_o
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD
`ifdef DLX_IF_BOUNDS_CHECK_EN
    , ST_FAULT
`endif
  } state_t;

`ifdef DLX_IF_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ROM_LIMIT = ADDR_W'(ROM_DEPTH);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc, pc_next;
  logic                valid_next;
  logic [DATA_W-1:0]   instr_next;
  logic [ADDR_W-1:0]   ipc_next, inpc_next;
  logic                fetch_oob;

  // The ROM sees the PC register directly, so there is no combinational path
  // from any input to the ROM address.
  assign rom_addr_o = pc;

  // Constant-false in the default build, which removes the fault path entirely.
  assign fetch_oob = BOUNDS_EN && (pc >= ROM_LIMIT);

`ifdef DLX_IF_BOUNDS_CHECK_EN
  logic fault_q, fault_next;
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      if_valid_o <= 1'b0;
      if_instr_o <= '0;
      if_pc_o    <= '0;
      if_npc_o   <= '0;
`ifdef DLX_IF_BOUNDS_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      if_valid_o <= valid_next;
      if_instr_o <= instr_next;
      if_pc_o    <= ipc_next;
      if_npc_o   <= inpc_next;
`ifdef DLX_IF_BOUNDS_CHECK_EN
      fault_q    <= fault_next;
`endif
    end
  end

  // NOTE: every signal written here gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = if_valid_o;
    instr_next = if_instr_o;
    ipc_next   = if_pc_o;
    inpc_next  = if_npc_o;
`ifdef DLX_IF_BOUNDS_CHECK_EN
    fault_next = fault_q;
`endif

    case (state)
      // One-cycle bubble after reset: the ROM word at RESET_PC is presented
      // during this cycle and captured on the next edge.
      ST_BOOT: state_next = ST_RUN;

      ST_RUN, ST_HOLD: begin
        if (branch_taken_i) begin
          // Redirect squashes the word currently fetched; if_pc/if_npc keep
          // describing the last real instruction.
          pc_next    = branch_target_i;
          valid_next = 1'b0;
          instr_next = '0;
          state_next = ST_RUN;
        end else if (stall_i) begin
          state_next = ST_HOLD;
        end else if (fetch_oob) begin
`ifdef DLX_IF_BOUNDS_CHECK_EN
          state_next = ST_FAULT;
          fault_next = 1'b1;
          valid_next = 1'b0;
          instr_next = '0;
`endif
        end else begin
          instr_next = rom_data_i;
          ipc_next   = pc;
          inpc_next  = pc + ADDR_W'(1);
          valid_next = 1'b1;
          pc_next    = pc + ADDR_W'(1);
          state_next = ST_RUN;
        end
      end

`ifdef DLX_IF_BOUNDS_CHECK_EN
      // Sticky until reset; stall and branch are ignored.
      ST_FAULT: state_next = ST_FAULT;
`endif

      default: state_next = ST_BOOT;
    endcase
  end

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_dlx_fetch_unit
//
// Self-checking bench for dlx_fetch_unit. A combinational ROM model answers the
// fetch address. Directed table vectors cover boot, sequential fetch, stall,
// branch-over-stall and PC wrap; hand-written sequences cover asynchronous reset
// mid-hold and the out-of-bounds behaviour; a randomized phase compares against
// a rule-level reference model.
// -----------------------------------------------------------------------------
module tb_dlx_fetch_unit;

`ifdef DLX_IF_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_npc_o;
  logic        fault_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom_mem [64];

  always #5 clk_i = ~clk_i;

  dlx_fetch_unit dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .if_valid_o      (if_valid_o),
    .if_instr_o      (if_instr_o),
    .if_pc_o         (if_pc_o),
    .if_npc_o        (if_npc_o),
    .fault_o         (fault_o)
  );

  // Out-of-range addresses return a recognisable tag so captures there are
  // still distinguishable.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd64) return rom_mem[a[5:0]];
    return {16'hBAD0, a[15:0]};
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] p, input logic [31:0] np,
                           input logic [31:0] ad, input logic f);
    check({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, v});
    check({tag, ".instr"}, if_instr_o, ins);
    check({tag, ".pc"},    if_pc_o, p);
    check({tag, ".npc"},   if_npc_o, np);
    check({tag, ".addr"},  rom_addr_o, ad);
    check({tag, ".fault"}, {31'd0, fault_o}, {31'd0, f});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- reference model (rule level) ----------------
  logic        m_boot, m_fault, m_valid;
  logic [31:0] m_pc, m_instr, m_pc_o, m_npc;

  task automatic model_reset();
    m_boot = 1'b1; m_fault = 1'b0; m_valid = 1'b0;
    m_pc = '0; m_instr = '0; m_pc_o = '0; m_npc = '0;
  endtask

  task automatic model_edge(input logic st, input logic br, input logic [31:0] tgt);
    if (m_boot) m_boot = 1'b0;
    else if (m_fault) begin end
    else if (br) begin
      m_pc = tgt; m_valid = 1'b0; m_instr = '0;
    end else if (st) begin end
    else if (BOUNDS_EN && m_pc >= 32'd64) begin
      m_fault = 1'b1; m_valid = 1'b0; m_instr = '0;
    end else begin
      m_instr = rom_word(m_pc);
      m_pc_o  = m_pc;
      m_npc   = m_pc + 32'd1;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd1;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [15];

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    rom_mem[0]  = 32'h40220000;
    rom_mem[1]  = 32'h40230000;
    rom_mem[2]  = 32'h40240000;
    rom_mem[3]  = 32'h40250000;
    rom_mem[4]  = 32'h6844000A;
    rom_mem[5]  = 32'h40450001;
    rom_mem[15] = 32'h40450001;

    //          stall br  tgt           valid instr          pc            npc           addr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        32'h0};        // BOOT bubble
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40220000, 32'h0,        32'h1,        32'h1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40230000, 32'h1,        32'h2,        32'h2};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40240000, 32'h2,        32'h3,        32'h3};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40250000, 32'h3,        32'h4,        32'h4};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h6844000A, 32'h4,        32'h5,        32'h5};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h6844000A, 32'h4,        32'h5,        32'h5};        // stall x3
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h6844000A, 32'h4,        32'h5,        32'h5};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h6844000A, 32'h4,        32'h5,        32'h5};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40450001, 32'h5,        32'h6,        32'h6};        // release
    vecs[10] = '{1'b1, 1'b1, 32'h0F,       1'b0, 32'h0,        32'h5,        32'h6,        32'h0F};       // branch beats stall
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40450001, 32'h0F,       32'h10,       32'h10};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0F,       32'h10,       32'hFFFFFFFF}; // wrap setup
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hBAD0FFFF, 32'hFFFFFFFF, 32'h0,        32'h0};        // wrap
    vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40220000, 32'h0,        32'h1,        32'h1};

    // Reset state, checked while reset is held.
    repeat (3) step();
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    reset_i = 1'b1;

    for (int i = 0; i < 15; i++) begin
      stall_i = vecs[i].stall;
      branch_taken_i = vecs[i].br;
      branch_target_i = vecs[i].tgt;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                vecs[i].e_pc, vecs[i].e_npc, vecs[i].e_addr, 1'b0);
    end
    branch_taken_i = 1'b0;

    // Async reset pulsed mid-HOLD, between edges.
    stall_i = 1'b1;
    step();
    step();
    check("hold.addr", rom_addr_o, 32'h1);
    #3 reset_i = 1'b0;
    #1 check_all("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1 reset_i = 1'b1;
    step();  // stall still high: BOOT ignores it
    check_all("reboot_bubble", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    stall_i = 1'b0;
    step();
    check_all("reboot_cap", 1'b1, 32'h40220000, 32'h0, 32'h1, 32'h1, 1'b0);

    // Branch to the first out-of-range word.
    branch_taken_i = 1'b1; branch_target_i = 32'd64;
    step();
    check_all("oob_br", 1'b0, 32'h0, 32'h0, 32'h1, 32'd64, 1'b0);
    branch_taken_i = 1'b0;
    step();
    if (BOUNDS_EN) begin
      check_all("oob_fault", 1'b0, 32'h0, 32'h0, 32'h1, 32'd64, 1'b1);
      branch_taken_i = 1'b1; branch_target_i = 32'd3;
      step();
      check_all("fault_sticky", 1'b0, 32'h0, 32'h0, 32'h1, 32'd64, 1'b1);
      branch_taken_i = 1'b0;
    end else begin
      check_all("oob_nocheck", 1'b1, 32'hBAD00040, 32'd64, 32'd65, 32'd65, 1'b0);
      step();
      check_all("oob_nocheck2", 1'b1, 32'hBAD00041, 32'd65, 32'd66, 32'd66, 1'b0);
    end
    #2 reset_i = 1'b0;
    #1 check("fault_clr", {31'd0, fault_o}, 32'h0);
    #1 reset_i = 1'b1;

    // Randomized phase against the reference model.
    model_reset();
    begin
      int fault_age = 0;
      for (int n = 0; n < 3000; n++) begin
        logic st, br;
        logic [31:0] tgt;
        st = ($urandom_range(0, 9) < 3);
        br = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 9))
          0:       tgt = 32'hFFFFFFFF - $urandom_range(0, 2);
          1:       tgt = $urandom_range(60, 70);
          default: tgt = $urandom_range(0, 63);
        endcase
        stall_i = st; branch_taken_i = br; branch_target_i = tgt;
        model_edge(st, br, tgt);
        step();
        check_all("rand", m_valid, m_instr, m_pc_o, m_npc, m_pc, m_fault);
        fault_age = m_fault ? fault_age + 1 : 0;
        if (fault_age > 3 || $urandom_range(0, 199) == 0) begin
          #2 reset_i = 1'b0;
          model_reset();
          #1 check_all("rand_rst", m_valid, m_instr, m_pc_o, m_npc, m_pc, m_fault);
          #1 reset_i = 1'b1;
          fault_age = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
